aclint_device: RTL and testbench
================================

ACLINT_DEVICE -- requirements
Module: aclint_device

Interface
REQ-001 SHALL have parameter: TIMEBASE_DIV, 1, clk cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: bus_valid  input  1  request valid.
REQ-005 SHALL have port: bus_ready  output  1  request accepted when bus_valid && bus_ready.
REQ-006 SHALL have port: bus_addr  input  16  byte offset inside ACLINT window; bits [2:0] ignored.
REQ-007 SHALL have port: bus_wen  input  1  1 = write, 0 = read.
REQ-008 SHALL have port: bus_wdata  input  64  write data.
REQ-009 SHALL have port: bus_wmask  input  8  byte enables for writes.
REQ-010 SHALL have port: bus_rvalid  output  1  response valid, one cycle.
REQ-011 SHALL have port: bus_rdata  output  64  read data, qualified by bus_rvalid.
REQ-012 SHALL have port: aclint  aclint_if.master  --  drives mtip, msip, mtime (64) to csrunit.

Function
REQ-013 SHALL decode: 0x0000 MSIP (bit 0 only, other bits read 0); 0x4000 MTIMECMP (64); 0xBFF8 MTIME (64); all else unmapped.
REQ-014 SHALL implement a two-state handshake FSM: IDLE (bus_ready=1) -> RESP on accept; RESP (bus_ready=0, bus_rvalid=1) -> IDLE unconditionally next cycle.
REQ-015 SHALL respond exactly one cycle after accept; max throughput one request per two cycles.
REQ-016 SHALL capture read data at accept cycle (pre-increment mtime value) into bus_rdata; writes return bus_rdata=0.
REQ-017 SHALL apply writes at the accept edge, byte-wise per bus_wmask; unmasked bytes unchanged.
REQ-018 SHALL return 0 for unmapped reads and ignore unmapped writes; no error signalling.
REQ-019 SHALL increment a prescaler each cycle; when it reaches TIMEBASE_DIV-1 it SHALL clear and mtime SHALL increment by 1.
REQ-020 SHALL wrap mtime from 0xFFFF_FFFF_FFFF_FFFF to 0 with no side effect.
REQ-021 SHALL give an MTIME bus write priority over a same-cycle increment and clear the prescaler on that write.
REQ-022 SHALL drive aclint.mtip = (mtime >= mtimecmp), unsigned 64-bit compare of registered values (visible cycle after a write/increment).
REQ-023 SHALL drive aclint.msip = MSIP bit 0 register; aclint.mtime = mtime register.
REQ-024 SHALL keep bus_rvalid low whenever state is IDLE; bus_valid during RESP is not accepted and must be held by the requester.

Reset
REQ-025 SHALL, while rst=1: state IDLE, bus_rvalid=0, bus_rdata=0, mtime=0, prescaler=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, MSIP=0, hence mtip=0, msip=0, bus_ready=1 after release.
REQ-026 SHALL discard any in-flight response when rst asserts mid-transaction; no response after release.

Configuration
REQ-027 SHALL honour macro ACLINT_MTIME_WRITABLE_EN: defined -> MTIME writable per REQ-017/REQ-021; undefined -> MTIME writes ignored (still acknowledged), mtime only counts.

Verification
REQ-028 Reset release, TIMEBASE_DIV=1, idle 10 cycles -> read 0xBFF8 returns 10 (±1 per capture rule), mtip=0, msip=0.
REQ-029 Write MSIP=1 (wmask 0x01) -> msip=1 next cycle, read 0x0000 returns 1; write 0 -> msip=0.
REQ-030 Write MTIMECMP=20 at mtime=5 -> mtip=0 until mtime=20, then mtip=1; write MTIMECMP=0xFFFF_FFFF_FFFF_FFFF -> mtip=0 next cycle.
REQ-031 With ACLINT_MTIME_WRITABLE_EN: write MTIME=0xFFFF_FFFF_FFFF_FFFE -> two increments later mtime=0; without macro the write leaves mtime counting unchanged.
REQ-032 TIMEBASE_DIV=4 -> mtime increments every 4th cycle; back-to-back bus_valid -> bus_ready alternates 1/0, bus_rvalid one cycle after each accept.
REQ-033 Assert rst during RESP -> bus_rvalid=0 immediately, all registers at reset values, no stale response after release.

Source files
------------

// File: rtl/aclint_device_if.sv
`default_nettype none
// ============================================================================
// Module   : aclint_if
// Purpose  : Timer/software interrupt lines and mtime bus from ACLINT to csrunit.
// Revision : 1.0
// ============================================================================
interface aclint_if;
    logic        mtip;
    logic        msip;
    logic [63:0] mtime;

    modport master (output mtip, output msip, output mtime);
    modport slave  (input  mtip, input  msip, input  mtime);
endinterface
`default_nettype wire

// File: rtl/aclint_device.sv
`default_nettype none
// ============================================================================
// Module   : aclint_device
// Purpose  : ACLINT MSIP/MTIMECMP/MTIME block with a one-cycle response bus.
//            Macro ACLINT_MTIME_WRITABLE_EN makes MTIME bus-writable.
// Revision : 1.0
// ============================================================================
module aclint_device #(
    parameter int unsigned TIMEBASE_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_valid,
    output logic        bus_ready,
    input  logic [15:0] bus_addr,
    input  logic        bus_wen,
    input  logic [63:0] bus_wdata,
    input  logic [7:0]  bus_wmask,
    output logic        bus_rvalid,
    output logic [63:0] bus_rdata,
    aclint_if.master    aclint
);

    localparam logic [15:0] c_PRESC_MAX = 16'(TIMEBASE_DIV - 1);
    localparam logic [12:0] c_ADDR_MSIP = 13'h0000;
    localparam logic [12:0] c_ADDR_CMP  = 13'h0800;
    localparam logic [12:0] c_ADDR_TIME = 13'h17FF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t      r_state;
    logic [63:0] r_rdata;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [15:0] r_presc;
    logic        r_msip;

    logic        w_accept;
    logic        w_wr;
    logic        w_sel_msip;
    logic        w_sel_cmp;
    logic        w_sel_time;
    logic        w_tick;
    logic        w_mtime_wr;
    logic [63:0] w_wmask64;
    logic [63:0] w_cmp_merged;
    logic [63:0] w_mtime_next;
    logic [63:0] w_rdata;
    logic        w_unused;

    // Offset bits [2:0] select a byte lane within a 64-bit word and are not decoded.
    assign w_unused   = ^bus_addr[2:0];

    assign w_accept   = bus_valid && (r_state == ST_IDLE);
    assign w_wr       = w_accept && bus_wen;
    assign w_sel_msip = (bus_addr[15:3] == c_ADDR_MSIP);
    assign w_sel_cmp  = (bus_addr[15:3] == c_ADDR_CMP);
    assign w_sel_time = (bus_addr[15:3] == c_ADDR_TIME);
    assign w_tick     = (r_presc == c_PRESC_MAX);

    for (genvar gi = 0; gi < 8; gi++) begin : g_wmask
        assign w_wmask64[8*gi +: 8] = {8{bus_wmask[gi]}};
    end

    assign w_cmp_merged = (r_mtimecmp & ~w_wmask64) | (bus_wdata & w_wmask64);

`ifdef ACLINT_MTIME_WRITABLE_EN
    assign w_mtime_wr   = w_wr && w_sel_time;
    assign w_mtime_next = (r_mtime & ~w_wmask64) | (bus_wdata & w_wmask64);
`else
    assign w_mtime_wr   = 1'b0;
    assign w_mtime_next = r_mtime;
`endif

    always_comb begin
        w_rdata = '0;
        if (!bus_wen) begin
            if (w_sel_msip)
                w_rdata = {63'd0, r_msip};
            else if (w_sel_cmp)
                w_rdata = r_mtimecmp;
            else if (w_sel_time)
                w_rdata = r_mtime;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus_valid) begin
                        r_state <= ST_RESP;
                        r_rdata <= w_rdata;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtimecmp <= '1;
            r_msip     <= 1'b0;
        end else begin
            if (w_wr && w_sel_cmp)
                r_mtimecmp <= w_cmp_merged;
            if (w_wr && w_sel_msip && bus_wmask[0])
                r_msip <= bus_wdata[0];
        end
    end

    // A bus write to MTIME wins over the tick and restarts the timebase phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime <= '0;
            r_presc <= '0;
        end else if (w_mtime_wr) begin
            r_mtime <= w_mtime_next;
            r_presc <= '0;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    assign bus_ready    = (r_state == ST_IDLE);
    assign bus_rvalid   = (r_state == ST_RESP);
    assign bus_rdata    = r_rdata;

    assign aclint.mtip  = (r_mtime >= r_mtimecmp);
    assign aclint.msip  = r_msip;
    assign aclint.mtime = r_mtime;

endmodule
`default_nettype wire

// File: tb/tb_aclint_device.sv
`default_nettype none
// ============================================================================
// Module   : tb_aclint_device
// Purpose  : Self-checking bench for aclint_device (DIV=1 main unit, DIV=4 unit).
// Revision : 1.0
// ============================================================================
module tb_aclint_device;

    localparam int unsigned DIV1 = 1;
    localparam int unsigned DIV4 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_valid = 1'b0;
    logic        bus_ready;
    logic [15:0] bus_addr = '0;
    logic        bus_wen = 1'b0;
    logic [63:0] bus_wdata = '0;
    logic [7:0]  bus_wmask = '0;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;

    logic        b4_valid = 1'b0;
    logic        b4_ready;
    logic [15:0] b4_addr = 16'hBFF8;
    logic        b4_wen = 1'b0;
    logic [63:0] b4_wdata = '0;
    logic [7:0]  b4_wmask = '0;
    logic        b4_rvalid;
    logic [63:0] b4_rdata;

    aclint_if u_if1 ();
    aclint_if u_if4 ();

    aclint_device #(.TIMEBASE_DIV(DIV1)) dut (
        .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata),
        .bus_wmask(bus_wmask), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .aclint(u_if1)
    );

    aclint_device #(.TIMEBASE_DIV(DIV4)) dut4 (
        .clk(clk), .rst(rst), .bus_valid(b4_valid), .bus_ready(b4_ready),
        .bus_addr(b4_addr), .bus_wen(b4_wen), .bus_wdata(b4_wdata),
        .bus_wmask(b4_wmask), .bus_rvalid(b4_rvalid), .bus_rdata(b4_rdata),
        .aclint(u_if4)
    );

    always #5 clk = ~clk;

    // Clock edges seen since the last reset release.
    logic [63:0] cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 64'd1;
    end

    logic [63:0] m_base = '0;
    logic [63:0] m_bcyc = '0;
    logic [63:0] m_cmp  = '1;
    logic        m_msip = 1'b0;

    int total = 0;
    int bad   = 0;

    function automatic logic [63:0] m_mtime();
        return m_base + ((cyc - m_bcyc) / 64'(DIV1));
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] w,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = o;
        for (int i = 0; i < 8; i++)
            if (m[i]) r[8*i +: 8] = w[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk(nm, {63'd0, act}, {63'd0, exp});
    endtask

    task automatic model_reset();
        m_base = '0;
        m_bcyc = '0;
        m_cmp  = '1;
        m_msip = 1'b0;
    endtask

    task automatic chk_state(input string nm);
        chk({nm, "_mtime"}, u_if1.mtime, m_mtime());
        chkb({nm, "_msip"}, u_if1.msip, m_msip);
        chkb({nm, "_mtip"}, u_if1.mtip, m_mtime() >= m_cmp);
        chk({nm, "_mtime4"}, u_if4.mtime, cyc / 64'(DIV4));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_valid = 1'b0;
        b4_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One request on the DIV=1 unit; returns the observed and model read data.
    task automatic do_req(input logic wen, input logic [15:0] addr, input logic [63:0] wd,
                          input logic [7:0] wm, output logic [63:0] rd, output logic [63:0] exp);
        logic [63:0] pre;
        logic [12:0] a;
        @(negedge clk);
        bus_valid = 1'b1;
        bus_wen   = wen;
        bus_addr  = addr;
        bus_wdata = wd;
        bus_wmask = wm;
        chkb("req_ready_idle", bus_ready, 1'b1);
        chkb("req_rvalid_idle", bus_rvalid, 1'b0);
        pre = m_mtime();
        a   = addr[15:3];
        exp = '0;
        if (!wen) begin
            if (a == 13'h0000)      exp = {63'd0, m_msip};
            else if (a == 13'h0800) exp = m_cmp;
            else if (a == 13'h17FF) exp = pre;
        end
        @(posedge clk);
        #1;
        if (wen) begin
            if (a == 13'h0000 && wm[0]) m_msip = wd[0];
            if (a == 13'h0800)          m_cmp  = merge(m_cmp, wd, wm);
`ifdef ACLINT_MTIME_WRITABLE_EN
            if (a == 13'h17FF) begin
                m_base = merge(pre, wd, wm);
                m_bcyc = cyc;
            end
`endif
        end
        @(negedge clk);
        bus_valid = 1'b0;
        chkb("resp_rvalid", bus_rvalid, 1'b1);
        chkb("resp_ready", bus_ready, 1'b0);
        rd = bus_rdata;
        chk_state("resp");
    endtask

    typedef struct {
        logic        wen;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] exp_rd;
        logic        exp_msip;
    } vec_t;

    vec_t vt[19];

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd, ex, wd;
        logic [15:0] addr;
        logic [7:0]  wm;
        logic        wen;
        int          sel;

        vt[0]  = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'h0, 1'b0};
        vt[1]  = '{1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 64'h0, 1'b1};
        vt[2]  = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'h1, 1'b1};
        vt[3]  = '{1'b0, 16'h0005, 64'h0, 8'h00, 64'h1, 1'b1};
        vt[4]  = '{1'b1, 16'h0000, 64'h0, 8'hFE, 64'h0, 1'b1};
        vt[5]  = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'h1, 1'b1};
        vt[6]  = '{1'b1, 16'h0000, 64'h0, 8'h01, 64'h0, 1'b0};
        vt[7]  = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'h0, 1'b0};
        vt[8]  = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[9]  = '{1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'h0F, 64'h0, 1'b0};
        vt[10] = '{1'b0, 16'h4007, 64'h0, 8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0};
        vt[11] = '{1'b1, 16'h4000, 64'hAABB_CCDD_0000_0000, 8'hA0, 64'h0, 1'b0};
        vt[12] = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'hAAFF_CCFF_5566_7788, 1'b0};
        vt[13] = '{1'b1, 16'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b0};
        vt[14] = '{1'b0, 16'h1000, 64'h0, 8'h00, 64'h0, 1'b0};
        vt[15] = '{1'b0, 16'h4008, 64'h0, 8'h00, 64'h0, 1'b0};
        vt[16] = '{1'b0, 16'hBFF0, 64'h0, 8'h00, 64'h0, 1'b0};
        vt[17] = '{1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b0};
        vt[18] = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        chkb("rst_rvalid", bus_rvalid, 1'b0);
        chk("rst_rdata", bus_rdata, 64'h0);
        chkb("rst_ready", bus_ready, 1'b1);
        chk("rst_mtime", u_if1.mtime, 64'h0);
        chkb("rst_mtip", u_if1.mtip, 1'b0);
        chkb("rst_msip", u_if1.msip, 1'b0);
        rst = 1'b0;

        // Idle count after release.
        repeat (10) @(negedge clk);
        chk("idle10_mtime", u_if1.mtime, 64'd10);
        chkb("idle10_mtip", u_if1.mtip, 1'b0);
        chkb("idle10_msip", u_if1.msip, 1'b0);
        do_req(1'b0, 16'hBFF8, 64'h0, 8'h00, rd, ex);
        chk("idle_read_mtime", rd, 64'd11);

        for (int i = 0; i < 19; i++) begin
            do_req(vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].wmask, rd, ex);
            chk($sformatf("tbl%0d_rdata", i), rd, vt[i].exp_rd);
            chkb($sformatf("tbl%0d_msip", i), u_if1.msip, vt[i].exp_msip);
        end

`ifdef ACLINT_MTIME_WRITABLE_EN
        do_req(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, ex);
        chk("wrap_wr", u_if1.mtime, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        chk("wrap_ff", u_if1.mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("wrap_zero", u_if1.mtime, 64'h0);
`else
        do_req(1'b1, 16'hBFF8, 64'h0000_0000_0000_1234, 8'hFF, rd, ex);
        chk("rowr_ignored", u_if1.mtime, m_mtime());
        chk("rowr_rdata", rd, 64'h0);
        @(negedge clk);
        chk("rowr_counting", u_if1.mtime, m_mtime());
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk_state("idle");
            end
            sel = $urandom_range(0, 5);
            case (sel)
                0: addr = 16'h0000;
                1: addr = 16'h4000;
                2: addr = 16'hBFF8;
                3: addr = 16'h0008;
                4: addr = 16'hC000;
                default: addr = 16'h2000 | 16'($urandom & 32'h1FFF);
            endcase
            addr = addr | 16'($urandom_range(0, 7));
            wen  = 1'($urandom & 1);
            wm   = ($urandom & 1) ? 8'hFF : 8'($urandom);
            if (sel == 1 && ($urandom & 1))
                wd = m_mtime() + 64'($urandom_range(0, 6));
            else
                wd = {$urandom, $urandom};
            do_req(wen, addr, wd, wm, rd, ex);
            chk("rand_rdata", rd, ex);
        end

        // Compare threshold crossing.
        do_reset();
        repeat (3) @(negedge clk);
        do_req(1'b1, 16'h4000, 64'd20, 8'hFF, rd, ex);
        chk("cmp20_mtime", u_if1.mtime, 64'd5);
        chkb("cmp20_mtip_lo", u_if1.mtip, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chkb("cmp20_mtip", u_if1.mtip, m_mtime() >= 64'd20);
        end
        chkb("cmp20_mtip_hi", u_if1.mtip, 1'b1);
        do_req(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, ex);
        chkb("cmpmax_mtip", u_if1.mtip, 1'b0);

        // Back-to-back requests on the DIV=4 unit.
        @(negedge clk);
        b4_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chkb("b2b_ready", b4_ready, (k % 2) == 0);
            chkb("b2b_rvalid", b4_rvalid, (k % 2) == 1);
            if (k % 2 == 1)
                chk("b2b_rdata", b4_rdata, (cyc - 64'd1) / 64'(DIV4));
            chk("b2b_mtime4", u_if4.mtime, cyc / 64'(DIV4));
            @(negedge clk);
        end
        b4_valid = 1'b0;

        // Reset while a read response is in flight.
        do_req(1'b1, 16'h0000, 64'h1, 8'h01, rd, ex);
        chkb("pre_rst_msip", u_if1.msip, 1'b1);
        @(negedge clk);
        bus_valid = 1'b1;
        bus_wen   = 1'b0;
        bus_addr  = 16'h4000;
        @(posedge clk);
        #1;
        bus_valid = 1'b0;
        chkb("inflight_rvalid", bus_rvalid, 1'b1);
        chk("inflight_rdata", bus_rdata, m_cmp);
        rst = 1'b1;
        model_reset();
        #1;
        chkb("midrst_rvalid", bus_rvalid, 1'b0);
        chkb("midrst_ready", bus_ready, 1'b1);
        chk("midrst_rdata", bus_rdata, 64'h0);
        chk("midrst_mtime", u_if1.mtime, 64'h0);
        chkb("midrst_msip", u_if1.msip, 1'b0);
        chkb("midrst_mtip", u_if1.mtip, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chkb("postrst_rvalid", bus_rvalid, 1'b0);
            chkb("postrst_ready", bus_ready, 1'b1);
            chk_state("postrst");
        end
        do_req(1'b0, 16'h4000, 64'h0, 8'h00, rd, ex);
        chk("postrst_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
